spike_count_window: RTL and testbench

Multi-channel windowed spike counter for the SNN readout path. Counts spikes on NUM_CH parallel channels over a fixed window of WINDOW_LEN input beats. At each window boundary it snapshots all counts and streams them out one channel per beat over a valid/ready interface, while the next window keeps counting. It replaces single-channel free-running accumulators wherever per-window rate readout is needed.

---
 rtl/spike_count_pkg.sv | 18 +
 rtl/spike_counter_channel.sv | 38 +++
 rtl/spike_count_window.sv | 141 ++++++++++++++
 tb/tb_spike_count_window.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_count_pkg.sv
// Shared types and sizing helpers for the windowed spike counter.
package spike_count_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic int win_cnt_width(input int window_len);
        return $clog2(window_len);
    endfunction

    // Largest count representable in data_width bits; the clamp value when saturating.
    function automatic logic [63:0] sat_ceiling(input int data_width);
        return (64'd1 << data_width) - 64'd1;
    endfunction

endpackage

// File: rtl/spike_counter_channel.sv
// One live spike counter: increments on inc, clamps or wraps at the ceiling, clr wins over inc.
module spike_counter_channel
    import spike_count_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  inc,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  sat
);

    localparam logic [DATA_WIDTH-1:0] CEIL = DATA_WIDTH'(sat_ceiling(DATA_WIDTH));

    logic [DATA_WIDTH-1:0] r_count;
    logic                  r_sat;

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (inc) begin
            if (r_count == CEIL) begin
                r_sat   <= 1'b1;
                r_count <= SATURATE ? CEIL : {DATA_WIDTH{1'b0}};
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign count = r_count;
    assign sat   = r_sat;

endmodule

// File: rtl/spike_count_window.sv
// Multi-channel windowed spike counter: snapshots all channel counts at each window end
// and streams them out one channel per valid/ready beat while the next window counts.
module spike_count_window
    import spike_count_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int DATA_WIDTH = 16,
    parameter int WINDOW_LEN = 256,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    input  logic [NUM_CH-1:0]         in_spikes,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic [DATA_WIDTH-1:0]     out_count,
    output logic                      out_sat,
    output logic                      out_last,
    output logic                      overrun,
    output state_t                    dbg_state
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int WIN_W = win_cnt_width(WINDOW_LEN);
    localparam logic [WIN_W-1:0]      WIN_LAST = WIN_W'(WINDOW_LEN - 1);
    localparam logic [CH_W-1:0]       CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [DATA_WIDTH-1:0] CEIL     = DATA_WIDTH'(sat_ceiling(DATA_WIDTH));

    logic [WIN_W-1:0]      r_win;
    state_t                r_state;
    logic [CH_W-1:0]       r_ch;
    logic                  r_valid;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] r_count;
    logic                  r_sat;
    logic                  r_ovr;
    logic [DATA_WIDTH-1:0] r_bank [NUM_CH];
    logic [NUM_CH-1:0]     r_bank_sat;

    logic                  w_win_end;
    logic                  w_hs;
    logic                  w_final;
    logic                  w_load;
    logic                  w_ovr;
    logic [CH_W-1:0]       w_ch_nxt;
    logic [NUM_CH-1:0]     w_inc;
    logic [NUM_CH-1:0]     w_sat;
    logic [NUM_CH-1:0]     w_snap_sat;
    logic [DATA_WIDTH-1:0] w_cnt      [NUM_CH];
    logic [DATA_WIDTH-1:0] w_snap_cnt [NUM_CH];

    assign w_win_end = in_valid && (r_win == WIN_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_win <= '0;
        end else if (in_valid) begin
            r_win <= w_win_end ? '0 : r_win + 1'b1;
        end
    end

    // The live counters clear on the window-end edge, so the snapshot is their next value.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_inc[g] = in_valid & in_spikes[g];

        spike_counter_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .SATURATE   (SATURATE)
        ) u_ch (
            .clk   (clk),
            .rstn  (rstn),
            .inc   (w_inc[g]),
            .clr   (w_win_end),
            .count (w_cnt[g]),
            .sat   (w_sat[g])
        );

        assign w_snap_cnt[g] = !w_inc[g]          ? w_cnt[g] :
                               (w_cnt[g] == CEIL) ? (SATURATE ? CEIL : {DATA_WIDTH{1'b0}}) :
                                                    w_cnt[g] + 1'b1;
        assign w_snap_sat[g] = w_sat[g] | (w_inc[g] && (w_cnt[g] == CEIL));
    end

    assign w_hs     = (r_state == STREAM) && out_ready;
    assign w_final  = w_hs && r_last;
    assign w_load   = w_win_end && ((r_state == IDLE) || w_final);
    assign w_ovr    = w_win_end && (r_state == STREAM) && !w_final;
    assign w_ch_nxt = r_ch + 1'b1;

    // Readout FSM; a window end coinciding with the final handshake reloads straight into STREAM.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_ch       <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_count    <= '0;
            r_sat      <= 1'b0;
            r_ovr      <= 1'b0;
            r_bank_sat <= '0;
            for (int i = 0; i < NUM_CH; i++) r_bank[i] <= '0;
        end else begin
            if (w_ovr) r_ovr <= 1'b1;
            if (w_load) begin
                for (int i = 0; i < NUM_CH; i++) r_bank[i] <= w_snap_cnt[i];
                r_bank_sat <= w_snap_sat;
                r_state    <= STREAM;
                r_valid    <= 1'b1;
                r_ch       <= '0;
                r_last     <= 1'b0;
                r_count    <= w_snap_cnt[0];
                r_sat      <= w_snap_sat[0];
            end else if (w_hs) begin
                if (r_last) begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_ch    <= '0;
                    r_last  <= 1'b0;
                    r_count <= '0;
                    r_sat   <= 1'b0;
                end else begin
                    r_ch    <= w_ch_nxt;
                    r_last  <= (w_ch_nxt == CH_LAST);
                    r_count <= r_bank[w_ch_nxt];
                    r_sat   <= r_bank_sat[w_ch_nxt];
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_ch    = r_ch;
    assign out_count = r_count;
    assign out_sat   = r_sat;
    assign out_last  = r_last;
    assign overrun   = r_ovr;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_spike_count_window.sv
// Bench for spike_count_window: a saturating and a wrapping instance share one stimulus stream
// and are checked against a transaction-level model of windows, snapshots and readout.
module tb_spike_count_window;
    import spike_count_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 3;
    localparam int WL  = 12;

    logic       clk = 1'b0;
    logic       rstn;
    logic       in_valid;
    logic [3:0] in_spikes;
    logic       out_ready;

    logic [1:0] o_valid, o_sat, o_last, o_ovr;
    logic [1:0] o_ch  [2];
    logic [2:0] o_cnt [2];
    state_t     o_dbg [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Model: raw spike totals of the open window, beats seen, and the expected readout words.
    int         raw_live [NCH];
    int         win_beats;
    logic       ovr_exp;
    logic [10:0] exp_q[$];   // {last, ch[1:0], raw_count[7:0]}

    always #5 clk = ~clk;

    spike_count_window #(.NUM_CH(NCH), .DATA_WIDTH(DW), .WINDOW_LEN(WL), .SATURATE(1'b1)) u_dut_sat (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_spikes(in_spikes),
        .out_valid(o_valid[0]), .out_ready(out_ready), .out_ch(o_ch[0]), .out_count(o_cnt[0]),
        .out_sat(o_sat[0]), .out_last(o_last[0]), .overrun(o_ovr[0]), .dbg_state(o_dbg[0])
    );

    spike_count_window #(.NUM_CH(NCH), .DATA_WIDTH(DW), .WINDOW_LEN(WL), .SATURATE(1'b0)) u_dut_wrap (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_spikes(in_spikes),
        .out_valid(o_valid[1]), .out_ready(out_ready), .out_ch(o_ch[1]), .out_count(o_cnt[1]),
        .out_sat(o_sat[1]), .out_last(o_last[1]), .overrun(o_ovr[1]), .dbg_state(o_dbg[1])
    );

    // Instance 0 clamps at 2^DW-1, instance 1 reports the total modulo 2^DW.
    function automatic logic [2:0] want_cnt(input int d, input int raw);
        int v;
        v = (d == 0) ? ((raw > 7) ? 7 : raw) : (raw % 8);
        return 3'(v);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) raw_live[c] = 0;
        win_beats = 0;
        ovr_exp   = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_tick(input logic v, input logic [3:0] sp, input logic rdy);
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        if (v) begin
            for (int c = 0; c < NCH; c++) raw_live[c] += int'(sp[c]);
            win_beats++;
            if (win_beats == WL) begin
                if (exp_q.size() == 0) begin
                    for (int c = 0; c < NCH; c++)
                        exp_q.push_back({(c == NCH - 1), 2'(c), 8'(raw_live[c])});
                end else begin
                    ovr_exp = 1'b1;
                end
                for (int c = 0; c < NCH; c++) raw_live[c] = 0;
                win_beats = 0;
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge; the DUT consumes them at the next rising edge.
    task automatic cycle(input logic v, input logic [3:0] sp, input logic rdy);
        in_valid  = v;
        in_spikes = sp;
        out_ready = rdy;
        model_tick(v, sp, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_spikes = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({o_valid[d], o_ch[d], o_cnt[d], o_sat[d], o_last[d], o_ovr[d]} !== 9'd0 || o_dbg[d] !== IDLE) begin
                n_bad++;
                $display("FAIL reset dut%0d: valid=%b ch=%0d cnt=%0d sat=%b last=%b ovr=%b state=%0d, required all 0 / IDLE",
                         d, o_valid[d], o_ch[d], o_cnt[d], o_sat[d], o_last[d], o_ovr[d], o_dbg[d]);
            end
        end
    endtask

    task automatic test_basic_window();
        logic [3:0] sp;
        do_reset();
        for (int b = 0; b < WL; b++) begin
            for (int c = 0; c < NCH; c++) sp[c] = (b <= c);
            if (b == WL - 1) begin
                for (int d = 0; d < 2; d++) begin
                    n_cmp++;
                    if (o_valid[d] !== 1'b0) begin
                        n_bad++;
                        $display("FAIL basic_early dut%0d: valid=%b before window end, required 0", d, o_valid[d]);
                    end
                end
            end
            cycle(1'b1, sp, 1'b1);
        end
        for (int k = 0; k < NCH; k++) begin
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (o_valid[d] !== 1'b1 || o_ch[d] !== 2'(k) || o_cnt[d] !== 3'(k + 1) ||
                    o_sat[d] !== 1'b0 || o_last[d] !== (k == NCH - 1)) begin
                    n_bad++;
                    $display("FAIL basic_word dut%0d k=%0d: valid=%b ch=%0d cnt=%0d sat=%b last=%b, required 1 %0d %0d 0 %b",
                             d, k, o_valid[d], o_ch[d], o_cnt[d], o_sat[d], o_last[d], k, k + 1, k == NCH - 1);
                end
            end
            cycle(1'b0, 4'd0, 1'b1);
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (o_valid[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL basic_drop dut%0d: valid=%b after readout, required 0", d, o_valid[d]);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int b = 0; b < WL; b++) cycle(1'b1, 4'b0001, 1'b0);
        for (int r = 0; r < 3; r++) begin
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (o_valid[d] !== 1'b1 || o_ch[d] !== 2'd0 || o_cnt[d] !== ((d == 0) ? 3'd7 : 3'd4) || o_sat[d] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL sat_ch0 dut%0d hold=%0d: valid=%b ch=%0d cnt=%0d sat=%b, required 1 0 %0d 1",
                             d, r, o_valid[d], o_ch[d], o_cnt[d], o_sat[d], (d == 0) ? 7 : 4);
                end
            end
            cycle(1'b0, 4'd0, r == 2);
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (o_ch[d] !== 2'd1 || o_cnt[d] !== 3'd0 || o_sat[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL sat_ch1 dut%0d: ch=%0d cnt=%0d sat=%b, required 1 0 0", d, o_ch[d], o_cnt[d], o_sat[d]);
            end
        end
        repeat (4) cycle(1'b0, 4'd0, 1'b1);
    endtask

    task automatic test_random_stall();
        logic [10:0] e;
        do_reset();
        for (int n = 0; n < 200; n++) begin
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (o_valid[d] !== (exp_q.size() != 0) || o_ovr[d] !== ovr_exp) begin
                    n_bad++;
                    $display("FAIL rand_ctrl dut%0d n=%0d: valid=%b ovr=%b, required %b %b",
                             d, n, o_valid[d], o_ovr[d], exp_q.size() != 0, ovr_exp);
                end else if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    n_cmp++;
                    if (o_ch[d] !== e[9:8] || o_cnt[d] !== want_cnt(d, int'(e[7:0])) ||
                        o_sat[d] !== (e[7:0] > 8'd7) || o_last[d] !== e[10]) begin
                        n_bad++;
                        $display("FAIL rand_word dut%0d n=%0d: ch=%0d cnt=%0d sat=%b last=%b, required %0d %0d %b %b",
                                 d, n, o_ch[d], o_cnt[d], o_sat[d], o_last[d], e[9:8], want_cnt(d, int'(e[7:0])),
                                 e[7:0] > 8'd7, e[10]);
                    end
                end
            end
            cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_overrun();
        logic [10:0] e;
        do_reset();
        for (int n = 0; n < 2 * WL + 8; n++) begin
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (o_valid[d] !== (exp_q.size() != 0) || o_ovr[d] !== ovr_exp) begin
                    n_bad++;
                    $display("FAIL ovr_ctrl dut%0d n=%0d: valid=%b ovr=%b, required %b %b",
                             d, n, o_valid[d], o_ovr[d], exp_q.size() != 0, ovr_exp);
                end else if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    n_cmp++;
                    if (o_ch[d] !== e[9:8] || o_cnt[d] !== want_cnt(d, int'(e[7:0])) ||
                        o_sat[d] !== (e[7:0] > 8'd7) || o_last[d] !== e[10]) begin
                        n_bad++;
                        $display("FAIL ovr_word dut%0d n=%0d: ch=%0d cnt=%0d sat=%b last=%b, required %0d %0d %b %b",
                                 d, n, o_ch[d], o_cnt[d], o_sat[d], o_last[d], e[9:8], want_cnt(d, int'(e[7:0])),
                                 e[7:0] > 8'd7, e[10]);
                    end
                end
            end
            if (n < 2 * WL) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b0);
            else            cycle(1'b0, 4'd0, 1'b1);
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (o_ovr[d] !== 1'b1 || o_valid[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL ovr_final dut%0d: ovr=%b valid=%b, required 1 0", d, o_ovr[d], o_valid[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] e;
        do_reset();
        for (int n = 0; n < 2 * WL + 6; n++) begin
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (o_valid[d] !== (exp_q.size() != 0) || o_ovr[d] !== ovr_exp) begin
                    n_bad++;
                    $display("FAIL b2b_ctrl dut%0d n=%0d: valid=%b ovr=%b, required %b %b",
                             d, n, o_valid[d], o_ovr[d], exp_q.size() != 0, ovr_exp);
                end else if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    n_cmp++;
                    if (o_ch[d] !== e[9:8] || o_cnt[d] !== want_cnt(d, int'(e[7:0])) ||
                        o_sat[d] !== (e[7:0] > 8'd7) || o_last[d] !== e[10]) begin
                        n_bad++;
                        $display("FAIL b2b_word dut%0d n=%0d: ch=%0d cnt=%0d sat=%b last=%b, required %0d %0d %b %b",
                                 d, n, o_ch[d], o_cnt[d], o_sat[d], o_last[d], e[9:8], want_cnt(d, int'(e[7:0])),
                                 e[7:0] > 8'd7, e[10]);
                    end
                end
            end
            // Readout of window 1 completes on the same edge as window 2's end beat.
            if (n < WL)              cycle(1'b1, 4'($urandom_range(0, 15)), 1'b0);
            else if (n < 2 * WL - 4) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b0);
            else if (n < 2 * WL)     cycle(1'b1, 4'($urandom_range(0, 15)), 1'b1);
            else                     cycle(1'b0, 4'd0, 1'b1);
            if (n == 2 * WL - 1) begin
                for (int d = 0; d < 2; d++) begin
                    n_cmp++;
                    if (o_valid[d] !== 1'b1 || o_ch[d] !== 2'd0 || o_ovr[d] !== 1'b0) begin
                        n_bad++;
                        $display("FAIL b2b_reload dut%0d: valid=%b ch=%0d ovr=%b, required 1 0 0",
                                 d, o_valid[d], o_ch[d], o_ovr[d]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [10:0] e;
        do_reset();
        for (int b = 0; b < WL; b++) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b1);
        repeat (2) cycle(1'b1, 4'hF, 1'b1);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (o_valid[d] !== 1'b1 || o_ch[d] !== 2'd2) begin
                n_bad++;
                $display("FAIL rst_pre dut%0d: valid=%b ch=%0d, required 1 2", d, o_valid[d], o_ch[d]);
            end
        end
        rstn      = 1'b0;
        in_valid  = 1'b1;
        in_spikes = 4'hF;
        out_ready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        for (int n = 0; n < WL + 6; n++) begin
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (o_valid[d] !== (exp_q.size() != 0) || o_ovr[d] !== ovr_exp) begin
                    n_bad++;
                    $display("FAIL rst_ctrl dut%0d n=%0d: valid=%b ovr=%b, required %b %b",
                             d, n, o_valid[d], o_ovr[d], exp_q.size() != 0, ovr_exp);
                end else if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    n_cmp++;
                    if (o_ch[d] !== e[9:8] || o_cnt[d] !== want_cnt(d, int'(e[7:0])) ||
                        o_sat[d] !== (e[7:0] > 8'd7) || o_last[d] !== e[10]) begin
                        n_bad++;
                        $display("FAIL rst_word dut%0d n=%0d: ch=%0d cnt=%0d sat=%b last=%b, required %0d %0d %b %b",
                                 d, n, o_ch[d], o_cnt[d], o_sat[d], o_last[d], e[9:8], want_cnt(d, int'(e[7:0])),
                                 e[7:0] > 8'd7, e[10]);
                    end
                end
            end
            if (n < WL) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b1);
            else        cycle(1'b0, 4'd0, 1'b1);
        end
    endtask

    task automatic test_alt_valid();
        logic [10:0] e;
        do_reset();
        for (int n = 0; n < 2 * WL + 6; n++) begin
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (o_valid[d] !== (exp_q.size() != 0) || o_ovr[d] !== ovr_exp) begin
                    n_bad++;
                    $display("FAIL alt_ctrl dut%0d n=%0d: valid=%b ovr=%b, required %b %b",
                             d, n, o_valid[d], o_ovr[d], exp_q.size() != 0, ovr_exp);
                end else if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    n_cmp++;
                    if (o_ch[d] !== e[9:8] || o_cnt[d] !== want_cnt(d, int'(e[7:0])) ||
                        o_sat[d] !== (e[7:0] > 8'd7) || o_last[d] !== e[10]) begin
                        n_bad++;
                        $display("FAIL alt_word dut%0d n=%0d: ch=%0d cnt=%0d sat=%b last=%b, required %0d %0d %b %b",
                                 d, n, o_ch[d], o_cnt[d], o_sat[d], o_last[d], e[9:8], want_cnt(d, int'(e[7:0])),
                                 e[7:0] > 8'd7, e[10]);
                    end
                end
            end
            // Spikes are presented on invalid cycles too and must be ignored.
            cycle(n[0], 4'($urandom_range(0, 15)), 1'b1);
        end
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_spikes = '0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic_window();
        test_saturate();
        test_random_stall();
        test_overrun();
        test_back_to_back();
        test_reset_mid_stream();
        test_alt_valid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
